// File: rtl/tqv_bus_pkg.sv
// Shared definitions for the TinyQV peripheral bus arbiter.
// Contents:
//   SZ_*          - 2-bit write/read strobe encodings (11 = inactive)
//   TIMEOUT_RDATA - read data returned when a read is aborted by the watchdog
//   state_t       - sequencer states
//   owner_onehot  - turns a 1-bit requester index into a one-hot port vector
package tqv_bus_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_NONE = 2'b11;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RESP
  } state_t;

  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/tqv_rr_arb2.sv
// Two-way round-robin picker, purely combinational.
// Ports:
//   valid      in  2  request valid per requester
//   last_grant in  1  index of the requester granted most recently
//   grant      out 2  one-hot winner (zero when nobody is valid)
// When both requesters are valid, the one that did not win last time wins.
module tqv_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/tqv_periph_bus_arbiter.sv
// Shares the single TinyQV peripheral register bus between two requesters
// (port 0: SPI host bridge, port 1: on-chip config/table loader). One bus
// transaction is in flight at a time; grants rotate round-robin.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready         per-requester request handshake (ready = one-cycle accept)
//   req_addr/wdata/write_n/read_n  packed per-requester request fields {port1, port0}
//   rsp_valid/rsp_rdata/rsp_err one-cycle completion pulse with read data / timeout flag
//   address/data_in             peripheral address and write data
//   data_write_n/data_read_n    peripheral strobes (11 = idle)
//   data_out/data_ready         peripheral read data and read-complete
module tqv_periph_bus_arbiter
  import tqv_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TIMEOUT_W      = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [11:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [3:0]  req_write_n,
  input  logic [3:0]  req_read_n,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [5:0]  address,
  output logic [31:0] data_in,
  output logic [1:0]  data_write_n,
  output logic [1:0]  data_read_n,
  input  logic [31:0] data_out,
  input  logic        data_ready
);

  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic                 owner;       // requester index of the transaction in flight
  logic                 last_grant;
  logic                 bad_req;     // captured request had an illegal strobe pair
  logic [TIMEOUT_W-1:0] wait_cnt;

  logic [1:0]  grant;
  logic        win;
  logic [5:0]  sel_addr;
  logic [31:0] sel_wdata;
  logic [1:0]  sel_wr;
  logic [1:0]  sel_rd;
  logic        sel_illegal;

  tqv_rr_arb2 u_arb (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Route the winning requester's fields; only meaningful while grant != 0.
  assign win         = grant[1];
  assign sel_addr    = win ? req_addr[11:6]     : req_addr[5:0];
  assign sel_wdata   = win ? req_wdata[63:32]   : req_wdata[31:0];
  assign sel_wr      = win ? req_write_n[3:2]   : req_write_n[1:0];
  assign sel_rd      = win ? req_read_n[3:2]    : req_read_n[1:0];
  // Exactly one of write/read must be active; both or neither is rejected.
  assign sel_illegal = (sel_wr != SZ_NONE) == (sel_rd != SZ_NONE);

  // Accept is combinational so the strobe lands on the cycle after it.
  assign req_ready = (state == ST_IDLE && !rst) ? grant : 2'b00;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      bad_req      <= 1'b0;
      wait_cnt     <= '0;
      rsp_valid    <= 2'b00;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      address      <= '0;
      data_in      <= '0;
      data_write_n <= SZ_NONE;
      data_read_n  <= SZ_NONE;
    end else begin
      rsp_valid <= 2'b00;
      unique case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            owner      <= win;
            last_grant <= win;
            wait_cnt   <= '0;
            bad_req    <= sel_illegal;
            if (sel_illegal) begin
              // Illegal requests reuse the write slot with the strobe left
              // idle, so their error response arrives with write timing.
              state <= ST_WRITE;
            end else if (sel_wr != SZ_NONE) begin
              address      <= sel_addr;
              data_in      <= sel_wdata;
              data_write_n <= sel_wr;
              state        <= ST_WRITE;
            end else begin
              address     <= sel_addr;
              data_in     <= sel_wdata;
              data_read_n <= sel_rd;
              state       <= ST_READ;
            end
          end
        end

        ST_WRITE: begin
          data_write_n <= SZ_NONE;
          rsp_valid    <= owner_onehot(owner);
          rsp_rdata    <= '0;
          rsp_err      <= bad_req;
          state        <= ST_RESP;
        end

        ST_READ: begin
          // Data takes priority over the watchdog when both hit together.
          if (data_ready) begin
            data_read_n <= SZ_NONE;
            rsp_valid   <= owner_onehot(owner);
            rsp_rdata   <= data_out;
            rsp_err     <= 1'b0;
            state       <= ST_RESP;
          end else if (wait_cnt == CNT_LAST) begin
            data_read_n <= SZ_NONE;
            rsp_valid   <= owner_onehot(owner);
            rsp_rdata   <= TIMEOUT_RDATA;
            rsp_err     <= 1'b1;
            state       <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_RESP: begin
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tqv_periph_bus_arbiter.sv
module tb_tqv_periph_bus_arbiter;
  import tqv_bus_pkg::*;

  typedef struct packed {
    logic [1:0]  owner;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [11:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_write_n;
  logic [3:0]  req_read_n;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  logic model_last;  // bench's own record of the most recent grant

  always #5 clk = ~clk;

  tqv_periph_bus_arbiter #(.TIMEOUT_CYCLES(64), .TIMEOUT_W(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_write_n  (req_write_n),
    .req_read_n   (req_read_n),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .address      (address),
    .data_in      (data_in),
    .data_write_n (data_write_n),
    .data_read_n  (data_read_n),
    .data_out     (data_out),
    .data_ready   (data_ready)
  );

  task automatic set_port(input int p, input logic [1:0] wr, input logic [1:0] rd,
                          input logic [5:0] a, input logic [31:0] d);
    if (p == 0) begin
      req_write_n[1:0] = wr;
      req_read_n[1:0]  = rd;
      req_addr[5:0]    = a;
      req_wdata[31:0]  = d;
    end else begin
      req_write_n[3:2] = wr;
      req_read_n[3:2]  = rd;
      req_addr[11:6]   = a;
      req_wdata[63:32] = d;
    end
  endtask

  // Waits (bounded) for a completion pulse, then pops and compares it.
  task automatic collect_rsp(input string name, input int budget);
    int   n = 0;
    exp_t e;
    while (rsp_valid === 2'b00 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (rsp_valid === 2'b00) begin
      bad++;
      $display("FAIL %s: no rsp_valid within %0d cycles", name, budget);
    end else if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: unexpected rsp_valid=%b, scoreboard empty", name, rsp_valid);
    end else begin
      e = sb.pop_front();
      if ({rsp_valid, rsp_rdata, rsp_err} !== e) begin
        bad++;
        $display("FAIL %s: got valid=%b rdata=%h err=%b, want valid=%b rdata=%h err=%b",
                 name, rsp_valid, rsp_rdata, rsp_err, e.owner, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    data_ready = 1'b0;
    data_out   = '0;
    set_port(0, SZ_WORD, SZ_NONE, 6'h2A, 32'h1111_1111);
    set_port(1, SZ_WORD, SZ_NONE, 6'h15, 32'h2222_2222);
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, address, data_in} !== '0) begin
      bad++;
      $display("FAIL reset_zero: ready=%b rsp_valid=%b rdata=%h err=%b addr=%h din=%h, want all 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err, address, data_in);
    end
    total++;
    if (data_write_n !== SZ_NONE || data_read_n !== SZ_NONE) begin
      bad++;
      $display("FAIL reset_strobes: wr=%b rd=%b, want 11 11", data_write_n, data_read_n);
    end
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle_ignore();
    logic seen = 1'b0;
    data_out   = 32'hDEAD_BEEF;
    data_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00 || rsp_rdata !== 32'h0 || data_read_n !== SZ_NONE) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL idle_data_ready: got rsp_valid=%b rdata=%h, want no response", rsp_valid, rsp_rdata);
    end
    data_ready = 1'b0;
  endtask

  task automatic test_write();
    set_port(0, SZ_WORD, SZ_NONE, 6'h04, 32'h1234_5678);
    req_valid = 2'b01;
    #1;
    total++;
    if (req_ready !== 2'b01) begin
      bad++;
      $display("FAIL write_ready: got %b want 01", req_ready);
    end
    sb.push_back(exp_t'{owner: 2'b01, rdata: 32'h0, err: 1'b0});
    model_last = 1'b0;
    @(negedge clk);
    req_valid = 2'b00;
    total++;
    if (data_write_n !== SZ_WORD || data_read_n !== SZ_NONE || rsp_valid !== 2'b00) begin
      bad++;
      $display("FAIL write_strobe: wr=%b rd=%b rsp=%b, want 10 11 00", data_write_n, data_read_n, rsp_valid);
    end
    total++;
    if (address !== 6'h04 || data_in !== 32'h1234_5678) begin
      bad++;
      $display("FAIL write_bus: addr=%h din=%h, want 04 12345678", address, data_in);
    end
    @(negedge clk);
    total++;
    if (data_write_n !== SZ_NONE) begin
      bad++;
      $display("FAIL write_strobe_drop: wr=%b want 11", data_write_n);
    end
    collect_rsp("write_rsp", 0);
    @(negedge clk);
    total++;
    if (address !== 6'h04 || data_in !== 32'h1234_5678) begin
      bad++;
      $display("FAIL idle_hold: addr=%h din=%h, want 04 12345678", address, data_in);
    end
  endtask

  task automatic test_read();
    set_port(1, SZ_NONE, SZ_BYTE, 6'h10, 32'h0);
    req_valid = 2'b10;
    #1;
    total++;
    if (req_ready !== 2'b10) begin
      bad++;
      $display("FAIL read_ready: got %b want 10", req_ready);
    end
    sb.push_back(exp_t'{owner: 2'b10, rdata: 32'h0000_00A5, err: 1'b0});
    model_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 2'b00;
      total++;
      if (data_read_n !== SZ_BYTE || data_write_n !== SZ_NONE || address !== 6'h10) begin
        bad++;
        $display("FAIL read_strobe_%0d: rd=%b wr=%b addr=%h, want 00 11 10", i, data_read_n, data_write_n, address);
      end
      if (i == 2) begin
        data_out   = 32'h0000_00A5;
        data_ready = 1'b1;
      end
    end
    @(negedge clk);
    data_ready = 1'b0;
    total++;
    if (data_read_n !== SZ_NONE) begin
      bad++;
      $display("FAIL read_strobe_drop: rd=%b want 11", data_read_n);
    end
    collect_rsp("read_rsp", 0);
    @(negedge clk);
  endtask

  task automatic test_alternate();
    int   grants = 0;
    int   rsps   = 0;
    int   cyc    = 0;
    logic [1:0] exp_g;
    set_port(0, SZ_WORD, SZ_NONE, 6'h01, 32'hA0A0_0001);
    set_port(1, SZ_NONE, SZ_HALF, 6'h02, 32'h0);
    data_out   = 32'hCAFE_0001;
    data_ready = 1'b1;
    req_valid  = 2'b11;
    while ((grants < 6 || rsps < 6) && cyc < 60) begin
      if (grants == 6) req_valid = 2'b00;
      #1;
      total++;
      if (data_write_n !== SZ_NONE && data_read_n !== SZ_NONE) begin
        bad++;
        $display("FAIL alt_overlap: wr=%b rd=%b both active", data_write_n, data_read_n);
      end
      if (rsp_valid !== 2'b00) begin
        collect_rsp("alt_rsp", 0);
        rsps++;
      end
      if (req_ready !== 2'b00 && grants < 6) begin
        exp_g = model_last ? 2'b01 : 2'b10;
        total++;
        if (req_ready !== exp_g) begin
          bad++;
          $display("FAIL alt_grant_%0d: got %b want %b", grants, req_ready, exp_g);
        end
        if (exp_g == 2'b01) sb.push_back(exp_t'{owner: 2'b01, rdata: 32'h0, err: 1'b0});
        else                sb.push_back(exp_t'{owner: 2'b10, rdata: 32'hCAFE_0001, err: 1'b0});
        model_last = ~model_last;
        grants++;
      end
      @(negedge clk);
      cyc++;
    end
    total++;
    if (grants != 6 || rsps != 6) begin
      bad++;
      $display("FAIL alt_count: grants=%0d rsps=%0d, want 6 6", grants, rsps);
    end
    req_valid  = 2'b00;
    data_ready = 1'b0;
    @(negedge clk);
  endtask

  // One read per call; assert_at > 0 raises data_ready in that strobe cycle.
  task automatic run_read(input string name, input int p, input int assert_at, input exp_t e);
    int held = 0;
    int n    = 0;
    set_port(p, SZ_NONE, SZ_WORD, 6'h3F, 32'h0);
    req_valid = (p == 0) ? 2'b01 : 2'b10;
    #1;
    total++;
    if (req_ready !== e.owner) begin
      bad++;
      $display("FAIL %s_ready: got %b want %b", name, req_ready, e.owner);
    end
    sb.push_back(e);
    model_last = p[0];
    @(negedge clk);
    req_valid = 2'b00;
    while (rsp_valid === 2'b00 && n < 200) begin
      if (data_read_n === SZ_WORD) begin
        held++;
        if (held == assert_at) begin
          data_out   = 32'h1357_9BDF;
          data_ready = 1'b1;
        end
      end
      @(negedge clk);
      n++;
    end
    data_ready = 1'b0;
    total++;
    if (held != 64) begin
      bad++;
      $display("FAIL %s_held: strobe held %0d cycles, want 64", name, held);
    end
    collect_rsp({name, "_rsp"}, 0);
    @(negedge clk);
  endtask

  task automatic test_timeout();
    run_read("timeout", 0, 0, exp_t'{owner: 2'b01, rdata: TIMEOUT_RDATA, err: 1'b1});
    run_read("ready_at_limit", 1, 64, exp_t'{owner: 2'b10, rdata: 32'h1357_9BDF, err: 1'b0});
  endtask

  task automatic run_illegal(input string name, input int p, input logic [1:0] code);
    logic [1:0] oh;
    oh = (p == 0) ? 2'b01 : 2'b10;
    set_port(p, code, code, 6'h33, 32'h5555_AAAA);
    req_valid = oh;
    #1;
    total++;
    if (req_ready !== oh) begin
      bad++;
      $display("FAIL %s_ready: got %b want %b", name, req_ready, oh);
    end
    sb.push_back(exp_t'{owner: oh, rdata: 32'h0, err: 1'b1});
    model_last = p[0];
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req_valid = 2'b00;
      total++;
      if (data_write_n !== SZ_NONE || data_read_n !== SZ_NONE) begin
        bad++;
        $display("FAIL %s_nobus_%0d: wr=%b rd=%b, want 11 11", name, i, data_write_n, data_read_n);
      end
    end
    collect_rsp({name, "_rsp"}, 0);
    @(negedge clk);
  endtask

  task automatic test_illegal();
    run_illegal("illegal_both", 0, SZ_WORD);
    run_illegal("illegal_none", 1, SZ_NONE);
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    set_port(0, SZ_NONE, SZ_BYTE, 6'h05, 32'h0);
    req_valid = 2'b01;
    #1;
    total++;
    if (req_ready !== 2'b01) begin
      bad++;
      $display("FAIL rstmid_ready: got %b want 01", req_ready);
    end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    total++;
    if (data_read_n !== SZ_BYTE) begin
      bad++;
      $display("FAIL rstmid_strobe: rd=%b want 00", data_read_n);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (data_read_n !== SZ_NONE) begin
      bad++;
      $display("FAIL rstmid_async: rd=%b want 11", data_read_n);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL rstmid_no_rsp: rsp_valid pulsed for aborted read");
    end
    set_port(0, SZ_WORD, SZ_NONE, 6'h07, 32'h0BAD_F00D);
    set_port(1, SZ_WORD, SZ_NONE, 6'h08, 32'h600D_F00D);
    req_valid = 2'b11;
    #1;
    total++;
    if (req_ready !== 2'b01) begin
      bad++;
      $display("FAIL rstmid_first_grant: got %b want 01", req_ready);
    end
    sb.push_back(exp_t'{owner: 2'b01, rdata: 32'h0, err: 1'b0});
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    collect_rsp("rstmid_rsp", 0);
    @(negedge clk);
  endtask

  initial begin
    req_valid   = 2'b00;
    req_addr    = '0;
    req_wdata   = '0;
    req_write_n = 4'hF;
    req_read_n  = 4'hF;
    test_reset();
    test_idle_ignore();
    test_write();
    test_read();
    test_alternate();
    test_timeout();
    test_illegal();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish by 200000 ns");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/tqv_periph_bus_arbiter.md
Name: tqv_periph_bus_arbiter

Overview:
Shares the single TinyQV peripheral register bus (6-bit address, 32-bit data, 2-bit write/read size strobes, data_ready) between two requesters: port 0 (SPI host bridge in the harness) and port 1 (on-chip config/table loader for the PRISM peripheral). It grants round-robin and sequences exactly one bus transaction at a time. Writes complete in one strobe cycle; reads hold until data_ready. A watchdog aborts reads that never complete. Sits between the harness front-end and the peripheral instance.

Parameters:
TIMEOUT_CYCLES, 64, max cycles a read strobe is held waiting for data_ready before abort (>=2)
TIMEOUT_W, 7, counter width, must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  2  per-requester request valid, bit i = requester i
req_ready  out  2  one-hot grant/accept pulse, high for the one cycle the request is captured
req_addr  in  12  {addr1[5:0], addr0[5:0]}
req_wdata  in  64  {wdata1, wdata0}
req_write_n  in  4  {wr1[1:0], wr0[1:0]}; 11 = not a write, 00 byte, 01 half, 10 word
req_read_n  in  4  {rd1, rd0}; same encoding; write and read both non-11 is illegal
rsp_valid  out  2  one-hot, one-cycle completion pulse to owning requester
rsp_rdata  out  32  read data, valid with rsp_valid (zero for writes)
rsp_err  out  1  timeout flag, valid with rsp_valid
address  out  6  peripheral address
data_in  out  32  peripheral write data
data_write_n  out  2  peripheral write strobe
data_read_n  out  2  peripheral read strobe
data_out  in  32  peripheral read data
data_ready  in  1  peripheral read-complete

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, address=0, data_in=0, data_write_n=11, data_read_n=11; state IDLE; last_grant=1 (so requester 0 wins first).
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE: if any req_valid: pick winner = the requester other than last_grant if it is valid, else the valid one. Pulse req_ready[winner], latch addr/wdata/size/owner, last_grant<=winner. Next state WRITE if write_n!=11, else READ if read_n!=11; illegal (both or neither !=11) -> RESP with rsp_err=1, no bus activity.
- Latency: bus strobe is driven the cycle after req_ready.
- WRITE: data_write_n=latched size, address/data_in driven, for exactly one cycle; -> RESP.
- READ: data_read_n=latched size held every cycle; counter increments. If data_ready: capture data_out into rsp_rdata, drop strobe next cycle, -> RESP. Else if counter reaches TIMEOUT_CYCLES-1: rsp_rdata=32'hFFFF_FFFF, rsp_err=1, -> RESP. data_ready in the same cycle as timeout: data wins, no error.
- data_ready while not in READ is ignored.
- RESP: rsp_valid[owner]=1 for one cycle, strobes 11; -> IDLE. Next grant possible in the cycle after RESP; minimum write throughput 1 per 3 cycles.
- address/data_in hold last values when idle; strobes always 11 outside WRITE/READ.
- req_valid dropped after grant has no effect; the transaction completes.
- Both requesters valid continuously: grants strictly alternate 0,1,0,1.
- rst mid-transaction: strobes return to 11 asynchronously, no rsp_valid ever issued for the aborted request.

Decomposition:
- Package tqv_bus_pkg: size encodings (SZ_BYTE=00, SZ_HALF=01, SZ_WORD=10, SZ_NONE=11), FSM state enum, TIMEOUT_RDATA constant 32'hFFFF_FFFF.
- Sub-module tqv_rr_arb2: 2-way round-robin picker (valid, last_grant -> one-hot grant), combinational; FSM and watchdog stay in the top.

Test Plan:
- Req0 word write addr 0x04 data 0x12345678 -> req_ready[0] cycle N, data_write_n=10 only in cycle N+1, address=0x04, rsp_valid[0] at N+2, rsp_err=0.
- Req1 byte read addr 0x10, peripheral raises data_ready 3 cycles after strobe with data_out 0xA5 -> data_read_n=00 held 3 cycles then 11, rsp_rdata=0x000000A5, rsp_valid[1].
- Both requesters valid for 6 transactions -> grants 0,1,0,1,0,1; never two strobes overlapping.
- Read with data_ready never asserted, TIMEOUT_CYCLES=64 -> strobe held exactly 64 cycles, rsp_err=1, rsp_rdata=0xFFFFFFFF.
- Request with write_n=10 and read_n=10 -> no strobe, rsp_err=1 two cycles after grant.
- Assert rst during READ -> data_read_n=11 same cycle, no rsp_valid, after release req0 granted first.
